// File: rtl/rca_clk.sv
// rca_clk: registered 32-bit ripple-carry adder (reference datapath).
// Input register -> 32-cell ripple-carry chain (eight 4-bit blocks) -> output register.
// Latency is two rising edges, with one new operation accepted every cycle.
// Optional feature macro: RCA_CLK_OVF_EN adds a registered signed-overflow output, ovf.
module rca_clk (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
`ifdef RCA_CLK_OVF_EN
  ,
  output logic        ovf
`endif
);

  logic [31:0] a_d, a_q;
  logic [31:0] b_d, b_q;
  logic        ci_d, ci_q;
  logic [31:0] s_d, s_q;
  logic        co_d, co_q;
  // Carry into each 4-bit block; blk_c[8] is the carry-out of bit 31.
  logic [8:0]  blk_c;

  // Stage-1 next state: capture operands every cycle, with no enable.
  always_comb begin
    a_d  = a;
    b_d  = b;
    ci_d = ci;
  end

  // Ripple core: full-adder cells chained inside each block, and block carries chained 0..7.
  always_comb begin : ripple_core
    logic c;
    s_d      = '0;
    blk_c    = '0;
    blk_c[0] = ci_q;
    for (int blk = 0; blk < 8; blk++) begin
      c = blk_c[blk];
      for (int k = 0; k < 4; k++) begin
        s_d[blk*4+k] = a_q[blk*4+k] ^ b_q[blk*4+k] ^ c;
        c = (a_q[blk*4+k] & b_q[blk*4+k]) | (a_q[blk*4+k] & c) | (b_q[blk*4+k] & c);
      end
      blk_c[blk+1] = c;
    end
    co_d = blk_c[8];
  end

  // Both pipeline stages; reset is synchronous and takes priority over capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      ci_q <= ci_d;
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

`ifdef RCA_CLK_OVF_EN
  logic ovf_d, ovf_q;

  // Two's-complement overflow: operands share a sign and the sum's sign differs from it.
  always_comb begin
    ovf_d = (a_q[31] == b_q[31]) & (s_d[31] != a_q[31]);
  end

  // Overflow flag is registered alongside s/co in stage 2.
  always_ff @(posedge clk) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_clk.sv
// Testbench for rca_clk: directed and random operands against a 33-bit arithmetic model.
// Build with RCA_CLK_OVF_EN defined to also check the ovf output.
module tb_rca_clk;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic        ci;
  logic [31:0] s;
  logic        co;
  logic [33:0] obs;   // {ovf, co, s}

  int tests = 0;
  int fails = 0;

`ifdef RCA_CLK_OVF_EN
  logic ovf;
  rca_clk dut (.clk(clk), .reset_n(reset_n), .a(a), .b(b), .ci(ci), .s(s), .co(co), .ovf(ovf));
  assign obs = {ovf, co, s};
`else
  rca_clk dut (.clk(clk), .reset_n(reset_n), .a(a), .b(b), .ci(ci), .s(s), .co(co));
  assign obs = {1'b0, co, s};
`endif

  always #5 clk = ~clk;

  // Reference: the exact unsigned sum gives {co,s}; the signed sum, checked against
  // the 32-bit signed range, gives the overflow flag.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [63:0] u;
    longint      sg;
    logic        o;
    u  = {32'd0, x} + {32'd0, y} + {63'd0, c};
    sg = longint'($signed(x)) + longint'($signed(y)) + longint'({63'd0, c});
    o  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
`ifndef RCA_CLK_OVF_EN
    o = 1'b0;
`endif
    return {o, u[32:0]};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; a = 32'd5; b = 32'd7; ci = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (obs !== 34'd0) begin
      fails++;
      $display("FAIL reset_hold: got ovf/co/s=%h exp %h", obs, 34'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 34'd0) begin
      fails++;
      $display("FAIL reset_release_gap: got ovf/co/s=%h exp %h", obs, 34'd0);
    end
    @(negedge clk);
    tests++;
    if (obs !== model(32'd5, 32'd7, 1'b0)) begin
      fails++;
      $display("FAIL reset_first_result: got ovf/co/s=%h exp %h", obs, model(32'd5, 32'd7, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [11] = '{32'd38297, 32'd376173, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd100,
                             32'd2147151326, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] tb_ [11] = '{32'd126625, 32'd421542, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd100,
                              32'd332321, 32'd1, 32'h80000000, 32'h80000000, 32'd0};
    logic        tc [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [33:0] exp_q [$];
    logic [33:0] e;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL b2b[%0d]: got ovf/co/s=%h exp %h", i - 2, obs, e);
        end
      end
      if (i < 11) begin
        a = ta[i]; b = tb_[i]; ci = tc[i];
        exp_q.push_back(model(ta[i], tb_[i], tc[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] exp_q [$];
    logic [33:0] e;
    logic [31:0] x, y;
    logic        c;
    for (int i = 0; i < 302; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL random[%0d]: got ovf/co/s=%h exp %h", i - 2, obs, e);
        end
      end
      if (i < 300) begin
        x = $urandom();
        y = $urandom();
        c = 1'($urandom_range(1, 0));
        // Bias some operands towards long carry chains and sign boundaries.
        case ($urandom_range(7, 0))
          0: y = ~x;
          1: x = 32'h7FFFFFFF;
          2: y = 32'h80000000;
          default: ;
        endcase
        a = x; b = y; ci = c;
        exp_q.push_back(model(x, y, c));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reset_n = 1'b1; a = 32'd1000; b = 32'd2345; ci = 1'b1;
    @(negedge clk);
    reset_n = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; ci = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 34'd0) begin
      fails++;
      $display("FAIL reset_mid_flush: got ovf/co/s=%h exp %h", obs, 34'd0);
    end
    reset_n = 1'b1; a = 32'hFFFF0000; b = 32'h00010000; ci = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 34'd0) begin
      fails++;
      $display("FAIL reset_mid_gap: got ovf/co/s=%h exp %h", obs, 34'd0);
    end
    a = 32'd0; b = 32'd0; ci = 1'b0;
    @(negedge clk);
    tests++;
    if (obs !== model(32'hFFFF0000, 32'h00010000, 1'b1)) begin
      fails++;
      $display("FAIL reset_mid_next: got ovf/co/s=%h exp %h", obs, model(32'hFFFF0000, 32'h00010000, 1'b1));
    end
  endtask

  initial begin
    reset_n = 1'b0; a = '0; b = '0; ci = 1'b0;
    test_reset();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
